// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer. Consumes the one-cycle tx_clk baud
// tick and shifts a captured byte out on txd as start, data (LSB first),
// optional parity and stop bits, with a ready/start handshake upstream and a
// one-cycle tx_done pulse when the last stop bit completes.
//
// Handshake: a byte is transferred on any rising clk_50mhz edge where
// tx_start and tx_ready are both 1; tx_ready is high exactly while the FSM is
// IDLE, and tx_start / tx_data are ignored at every other edge.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       tx_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       txd,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_e;

    localparam logic [7:0] DATA_MASK  = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic       txd_q, txd_d;
    logic       done_q, done_d;
    logic [7:0] data_masked;

    // Unused upper data bits are cleared so they never reach the parity.
    assign data_masked = tx_data & DATA_MASK;

    // State register; reset returns the FSM to IDLE immediately.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: everything past IDLE advances only on a baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tx_start) state_d = S_SYNC;
            S_SYNC:  if (tx_clk) state_d = S_START;
            S_START: if (tx_clk) state_d = S_DATA;
            S_DATA:  if (tx_clk && cnt_q == LAST_DATA) state_d = HAS_PARITY ? S_PAR : S_STOP;
            S_PAR:   if (tx_clk) state_d = S_STOP;
            S_STOP:  if (tx_clk && cnt_q == LAST_STOP) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: the value for each bit is loaded into txd on the
    // tick that starts that bit, so every bit lasts one full baud period.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_start) begin
                    shift_d = data_masked;
                    par_d   = (PARITY == 1) ? ~(^data_masked) : (^data_masked);
                    cnt_d   = 3'd0;
                end
            end
            S_SYNC: begin
                if (tx_clk) txd_d = 1'b0;
            end
            S_START: begin
                if (tx_clk) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = 3'd0;
                end
            end
            S_DATA: begin
                // cnt_q is the index of the data bit currently on the line.
                if (tx_clk) begin
                    if (cnt_q == LAST_DATA) begin
                        txd_d = HAS_PARITY ? par_q : 1'b1;
                        cnt_d = 3'd0;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (tx_clk) begin
                    txd_d = 1'b1;
                    cnt_d = 3'd0;
                end
            end
            S_STOP: begin
                // The counter is reused to count completed stop bits.
                if (tx_clk) begin
                    if (cnt_q == LAST_STOP) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    // Datapath registers; txd resets high so the line idles during reset.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 8'd0;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready  = (state_q == S_IDLE);
    assign tx_done   = done_q;
    assign txd       = txd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7N2)
// share one baud tick. Frames are checked cycle by cycle against
// hand-computed bit patterns (bit i = i-th bit on the line, start first).
module tb_uart_tx_frame;

    localparam int N = 434;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_clk;
    logic [7:0] data_v [4];
    logic [3:0] start_v;
    logic [3:0] ready_v;
    logic [3:0] done_v;
    logic [3:0] txd_v;
    logic [2:0] dbg_v [4];
    int         tick_cnt;
    int         n_vec  = 0;
    int         n_miss = 0;

    always #10 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_50mhz(clk), .rst_n(rst_n), .tx_clk(tx_clk), .tx_data(data_v[0]),
        .tx_start(start_v[0]), .tx_ready(ready_v[0]), .tx_done(done_v[0]),
        .txd(txd_v[0]), .dbg_state(dbg_v[0]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk_50mhz(clk), .rst_n(rst_n), .tx_clk(tx_clk), .tx_data(data_v[1]),
        .tx_start(start_v[1]), .tx_ready(ready_v[1]), .tx_done(done_v[1]),
        .txd(txd_v[1]), .dbg_state(dbg_v[1]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk_50mhz(clk), .rst_n(rst_n), .tx_clk(tx_clk), .tx_data(data_v[2]),
        .tx_start(start_v[2]), .tx_ready(ready_v[2]), .tx_done(done_v[2]),
        .txd(txd_v[2]), .dbg_state(dbg_v[2]));

    uart_tx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk_50mhz(clk), .rst_n(rst_n), .tx_clk(tx_clk), .tx_data(data_v[3]),
        .tx_start(start_v[3]), .tx_ready(ready_v[3]), .tx_done(done_v[3]),
        .txd(txd_v[3]), .dbg_state(dbg_v[3]));

    // Baud tick: one cycle high every N cycles, changed on the falling edge.
    initial begin
        tx_clk   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            if (tick_cnt == N - 1) begin
                tick_cnt = 0;
                tx_clk   = 1'b1;
            end else begin
                tick_cnt = tick_cnt + 1;
                tx_clk   = 1'b0;
            end
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: run exceeded 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] d, input bit hold);
        int w;
        w = 0;
        while (ready_v[idx] !== 1'b1 && w < 4 * N) begin
            step();
            w++;
        end
        chk($sformatf("ready_before_send%0d", idx), 32'(ready_v[idx]), 32'd1);
        data_v[idx]  = d;
        start_v[idx] = 1'b1;
        step();
        if (!hold) start_v[idx] = 1'b0;
    endtask

    // Called one cycle after the accept edge. exp_lat < 0 means any legal
    // start latency (1..N cycles from the accept edge) is acceptable.
    task automatic check_frame(input int idx, input string tag, input logic [15:0] bits,
                               input int nbits, input int exp_lat);
        int lat;
        int bad;
        int busy_bad;
        chk({tag, "/ready_low"}, 32'(ready_v[idx]), 32'd0);
        lat = 1;
        while (txd_v[idx] === 1'b1 && lat <= N + 2) begin
            step();
            lat++;
        end
        chk({tag, "/start_seen"}, 32'(txd_v[idx]), 32'd0);
        if (exp_lat >= 0)
            chk({tag, "/latency"}, 32'(lat - 1), 32'(exp_lat));
        else
            chk({tag, "/latency_range"}, 32'((lat - 1 >= 1) && (lat - 1 <= N)), 32'd1);
        busy_bad = 0;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < N; c++) begin
                if (txd_v[idx] !== bits[b]) bad++;
                if (done_v[idx] !== 1'b0 || ready_v[idx] !== 1'b0) busy_bad++;
                step();
            end
            chk($sformatf("%s/bit%0d_bad_cycles", tag, b), 32'(bad), 32'd0);
        end
        chk({tag, "/busy_flags_bad_cycles"}, 32'(busy_bad), 32'd0);
        chk({tag, "/done_pulse"}, 32'(done_v[idx]), 32'd1);
        chk({tag, "/ready_with_done"}, 32'(ready_v[idx]), 32'd1);
        chk({tag, "/txd_idle"}, 32'(txd_v[idx]), 32'd1);
        step();
        chk({tag, "/done_one_cycle"}, 32'(done_v[idx]), 32'd0);
    endtask

    initial begin
        int w;
        int bad;
        rst_n   = 1'b0;
        start_v = 4'h0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        steps(3);

        // Reset state
        chk("rst_txd", 32'(txd_v), 32'hF);
        chk("rst_ready", 32'(ready_v), 32'hF);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_state", 32'(dbg_v[0]), 32'd0);
        rst_n = 1'b1;
        step();

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        send(0, 8'h55, 1'b0);
        check_frame(0, "8n1_55", 16'h02AA, 10, -1);

        // 8E1 0xA7: start, 1,1,1,0,0,1,0,1, parity 1, stop
        send(1, 8'hA7, 1'b0);
        check_frame(1, "8e1_a7", 16'h074E, 11, -1);

        // 8O1 0xA7: parity 0
        send(2, 8'hA7, 1'b0);
        check_frame(2, "8o1_a7", 16'h054E, 11, -1);

        // 7N2 0xFF: start, seven 1s, two stop periods
        send(3, 8'hFF, 1'b0);
        check_frame(3, "7n2_ff", 16'h03FE, 10, -1);

        // 7N2 0x80: bit 7 must not appear on the line
        send(3, 8'h80, 1'b0);
        check_frame(3, "7n2_80", 16'h0300, 10, -1);

        // Mid-frame pulse of 0x3C is dropped; 0xC3 goes out unchanged
        send(0, 8'hC3, 1'b0);
        fork
            check_frame(0, "c3_pulse", 16'h0386, 10, -1);
            begin
                steps(3 * N);
                data_v[0]  = 8'h3C;
                start_v[0] = 1'b1;
                step();
                start_v[0] = 1'b0;
            end
        join
        bad = 0;
        for (int c = 0; c < 2 * N; c++) begin
            if (txd_v[0] !== 1'b1 || ready_v[0] !== 1'b1) bad++;
            step();
        end
        chk("pulse_dropped_idle_bad_cycles", 32'(bad), 32'd0);

        // Held request is accepted on the done cycle; start follows at the
        // next tick, N-1 cycles after that accept
        send(0, 8'hC3, 1'b0);
        fork
            check_frame(0, "c3_hold", 16'h0386, 10, -1);
            begin
                steps(2 * N);
                data_v[0]  = 8'h3C;
                start_v[0] = 1'b1;
            end
        join
        start_v[0] = 1'b0;
        check_frame(0, "3c_b2b", 16'h0278, 10, N - 1);

        // Tick coincident with accept: start bit waits a full N cycles
        w = 0;
        while (tx_clk !== 1'b1 && w < 2 * N) begin
            step();
            w++;
        end
        data_v[0]  = 8'h55;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        check_frame(0, "coinc_55", 16'h02AA, 10, N);

        // Asynchronous reset during DATA
        send(0, 8'h55, 1'b0);
        w = 0;
        while (txd_v[0] === 1'b1 && w < N + 2) begin
            step();
            w++;
        end
        steps(2 * N + N / 2);
        chk("pre_rst_txd_low", 32'(txd_v[0]), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd_v[0]), 32'd1);
        chk("mid_rst_ready", 32'(ready_v[0]), 32'd1);
        chk("mid_rst_done", 32'(done_v[0]), 32'd0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done_v[0] !== 1'b0 || txd_v[0] !== 1'b1) bad++;
        end
        chk("in_rst_bad_cycles", 32'(bad), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_done", 32'(done_v[0]), 32'd0);
        send(0, 8'h3C, 1'b0);
        check_frame(0, "post_rst_3c", 16'h0278, 10, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial framer for the UART transmit path. Sits directly downstream of the baud tick generator: it consumes the one-cycle `tx_clk` baud pulse and shifts a parallel byte out on `txd` as start, data, optional parity and stop bits. It exposes a ready/start handshake to the upstream byte source and a one-cycle completion pulse.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.

Ports:
- `clk_50mhz`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tx_clk`, input, 1: baud tick, high for one `clk_50mhz` cycle once per bit period.
- `tx_data`, input, 8: byte to send; only bits [DATA_BITS-1:0] are used.
- `tx_start`, input, 1: send request; accepted only while `tx_ready` = 1.
- `tx_ready`, output, 1: framer idle; a request is accepted this cycle.
- `tx_done`, output, 1: one-cycle pulse when the last stop bit completes.
- `txd`, output, 1: serial line; registered, idles high.

## Operation
- States:
  - IDLE: `tx_ready` = 1, `txd` = 1.
  - SYNC: waiting for the next baud tick.
  - START, DATA, PAR, STOP.
- Accept:
  - At an edge where `tx_start` & `tx_ready` are both 1, capture `tx_data[DATA_BITS-1:0]` into a shift register.
  - Compute parity from the captured bits: even = XOR of the bits; odd = inverted XOR.
  - Clear the bit counter and go to SYNC.
- Tick-driven transitions. Every transition out of SYNC, START, DATA, PAR and STOP happens only on an edge where `tx_clk` = 1; `txd` holds otherwise.
  - SYNC→START: `txd` ← 0.
  - START→DATA: `txd` ← bit0.
  - DATA: each tick outputs the next bit, LSB first. After bit DATA_BITS-1 has been held for one tick period:
    - go to PAR (`txd` ← parity) if PARITY≠0;
    - otherwise go to STOP (`txd` ← 1).
  - PAR→STOP: `txd` ← 1.
  - STOP: held for STOP_BITS tick periods. On the tick that ends the last stop bit, go to IDLE and pulse `tx_done`.
- Every bit therefore lasts exactly one baud period. The frame spans 1 + DATA_BITS + (PARITY≠0) + STOP_BITS ticks after SYNC exits.
- While not IDLE:
  - `tx_start` is ignored.
  - A `tx_data` change does not affect the frame in flight.
- The bit counter is 3 bits wide and is reused for the stop-bit count.
- Out-of-range parameter values are unsupported; no runtime check is made.

## Timing
- Reset values: `txd` = 1, `tx_ready` = 1, `tx_done` = 0, state IDLE, shift register 0. Reset is effective immediately, mid-frame included; the line returns high with no `tx_done`.
- Accept at edge k: `tx_ready` = 0 from cycle k+1.
- A `tx_clk` pulse coincident with the accept edge does not advance SYNC. The first tick sampled at an edge after k produces the start bit. Start latency is therefore 1 to N cycles, where N = FSYS_CLK/BAND_SET (default 434).
- On the final stop tick edge, `tx_done` = 1 and `tx_ready` = 1, both in the following cycle.
- Back-to-back: `tx_start` held high in that `tx_ready` cycle is accepted. The next start bit then begins at the following tick, so there is no extra idle bit.
- `tx_done` is never high for more than one cycle. `tx_done` and `tx_ready` rising happen in the same cycle.
- `txd` is glitch-free: it is a direct flop output.

## Test plan
- Reset: assert `rst_n` = 0 mid-DATA.
  - Required: `txd` = 1 and `tx_ready` = 1 asynchronously, `tx_done` stays 0.
  - After release, a new frame is sent correctly.
- 8N1, tick every 434 cycles, send 0x55.
  - Required `txd` from the start edge: 0,1,0,1,0,1,0,1,0,1, each exactly 434 cycles.
  - Then one `tx_done` pulse, with `tx_ready` rising in the same cycle.
- 8E1 with 0xA7 (five ones), then 8O1 with 0xA7.
  - Required parity bit: 1 for even, 0 for odd.
  - Data order: 1,1,1,0,0,1,0,1.
- 7N2 with 0xFF.
  - Required: 7 data bits of 1, then a stop high for 2 tick periods.
  - Bit 7 of the input is never transmitted.
  - Frame spans 10 ticks.
- Handshake: pulse `tx_start` with 0x3C mid-frame while 0xC3 is in flight.
  - Required: 0xC3 is sent unchanged and 0x3C is dropped.
  - Hold `tx_start` with 0x3C through `tx_done`; 0x3C is accepted on the `tx_done` cycle and its start bit follows at the next tick with no idle gap.
- Tick coincident with accept.
  - Required: the start bit waits for the next tick, giving an N-cycle latency, not 1.
